reg_snapshot_seq: RTL and testbench

- Monitor-side register-file snapshot sequencer for the MIPS checker path.
- On a start request it latches the current pc. It then walks the register file in pairs by driving the rs/rt read addresses that the checker interface carries into the CPU. It captures the returned rs_value/rt_value.
- Each pair is buffered with the pc tag in a small FIFO. The FIFO drains to the emulation transactor over a valid/ready handshake.

---
 rtl/reg_snapshot_seq.sv | 152 +++++++++++++++
 tb/tb_reg_snapshot_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_snapshot_seq.sv
// Register-file snapshot sequencer: walks r0..r31 in pairs, tags each pair with the
// pc latched at start, and streams the pairs out through a small valid/ready FIFO.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | driving rs/rt pair reads while FIFO credit allows
// WAIT  | last pair issued, waiting for its capture to be pushed
// DRAIN | waiting for the last entry to leave the FIFO
module reg_snapshot_seq #(
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] pc,
    input  logic [31:0] rs_value,
    input  logic [31:0] rt_value,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic        busy,
    output logic        start_drop,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [3:0]  out_idx,
    output logic [31:0] out_rs_data,
    output logic [31:0] out_rt_data,
    output logic        out_last
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  idx;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic        last;
    } entry_t;

    state_t         state, state_nxt;
    logic [31:0]    snap_pc;
    logic [3:0]     k;
    logic           pipe_valid;
    logic [3:0]     pipe_idx;
    entry_t         mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;

    logic           credit, issue, push, pop;
    logic [CW:0]    occupancy;
    logic [3:0]     push_idx;
    entry_t         push_entry;
    entry_t         head;

    // Credit ignores a same-cycle pop so an in-flight read always has a free slot.
    always_comb begin
        occupancy = {1'b0, count};
        if (RD_LAT == 1)
            occupancy = {1'b0, count} + {{CW{1'b0}}, pipe_valid};
        credit    = occupancy < (CW+1)'(FIFO_DEPTH);
        issue     = (state == ISSUE) && credit;
        out_valid = (count != '0);
        pop       = out_valid && out_ready;
        head      = mem[rd_ptr];

        push     = issue;
        push_idx = k;
        if (RD_LAT == 1) begin
            push     = pipe_valid;
            push_idx = pipe_idx;
        end
        push_entry.pc      = snap_pc;
        push_entry.idx     = push_idx;
        push_entry.rs_data = rs_value;
        push_entry.rt_data = rt_value;
        push_entry.last    = (push_idx == 4'd15);

        rs = 5'd0;
        rt = 5'd0;
        if (issue) begin
            rs = {k, 1'b0};
            rt = {k, 1'b1};
        end
    end

    assign busy        = (state != IDLE);
    assign out_pc      = out_valid ? head.pc      : 32'd0;
    assign out_idx     = out_valid ? head.idx     : 4'd0;
    assign out_rs_data = out_valid ? head.rs_data : 32'd0;
    assign out_rt_data = out_valid ? head.rt_data : 32'd0;
    assign out_last    = out_valid ? head.last    : 1'b0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = ISSUE;
            ISSUE: if (issue && k == 4'd15) state_nxt = WAIT;
            WAIT: begin
                // With zero read latency the last pair was already pushed while issuing.
                if (pop && head.last)
                    state_nxt = IDLE;
                else if ((push && push_entry.last) || RD_LAT == 0)
                    state_nxt = DRAIN;
            end
            DRAIN: if (pop && head.last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            snap_pc    <= 32'd0;
            k          <= 4'd0;
            pipe_valid <= 1'b0;
            pipe_idx   <= 4'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            start_drop <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                snap_pc <= pc;
                k       <= 4'd0;
            end else if (issue) begin
                k <= k + 4'd1;
            end
            if (start && state != IDLE)
                start_drop <= 1'b1;
            pipe_valid <= issue;
            pipe_idx   <= k;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_entry;
    end
endmodule

// File: tb/tb_reg_snapshot_seq.sv
// Directed bench for reg_snapshot_seq: one instance with registered reads, one with
// combinational reads, both fed from a regfile model where reg[i] = 0x1000 + i.
module tb_reg_snapshot_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start1, start0, out_ready, sel;
    logic [31:0] pc;
    logic [4:0]  rs1, rt1, rs0, rt0, rs1_q, rt1_q;
    logic [31:0] rsv1, rtv1, rsv0, rtv0;
    logic        busy1, drop1, valid1, last1, busy0, drop0, valid0, last0;
    logic [31:0] opc1, ors1, ort1, opc0, ors0, ort0;
    logic [3:0]  idx1, idx0;

    int total = 0;
    int bad = 0;

    int          q_idx[$];
    logic [31:0] q_rs[$], q_rt[$], q_pc[$];
    logic        q_last[$];

    always @(posedge clk) begin
        rs1_q <= rs1;
        rt1_q <= rt1;
    end
    assign rsv1 = 32'h1000 + {27'd0, rs1_q};
    assign rtv1 = 32'h1000 + {27'd0, rt1_q};
    assign rsv0 = 32'h1000 + {27'd0, rs0};
    assign rtv0 = 32'h1000 + {27'd0, rt0};

    reg_snapshot_seq #(.RD_LAT(1), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .start(start1), .pc(pc),
        .rs_value(rsv1), .rt_value(rtv1), .rs(rs1), .rt(rt1),
        .busy(busy1), .start_drop(drop1), .out_valid(valid1), .out_ready(out_ready),
        .out_pc(opc1), .out_idx(idx1), .out_rs_data(ors1), .out_rt_data(ort1),
        .out_last(last1)
    );

    reg_snapshot_seq #(.RD_LAT(0), .FIFO_DEPTH(8)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .pc(pc),
        .rs_value(rsv0), .rt_value(rtv0), .rs(rs0), .rt(rt0),
        .busy(busy0), .start_drop(drop0), .out_valid(valid0), .out_ready(out_ready),
        .out_pc(opc0), .out_idx(idx0), .out_rs_data(ors0), .out_rt_data(ort0),
        .out_last(last0)
    );

    logic        m_valid, m_last;
    logic [31:0] m_pc, m_rs, m_rt;
    logic [3:0]  m_idx;
    assign m_valid = sel ? valid1 : valid0;
    assign m_last  = sel ? last1  : last0;
    assign m_pc    = sel ? opc1   : opc0;
    assign m_rs    = sel ? ors1   : ors0;
    assign m_rt    = sel ? ort1   : ort0;
    assign m_idx   = sel ? idx1   : idx0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic q_clear();
        q_idx.delete(); q_rs.delete(); q_rt.delete(); q_pc.delete(); q_last.delete();
    endtask

    // Records handshaken entries; optional ready toggling, start injection and pc walking.
    task automatic collect(input string t, input int want, input int max_cyc, input bit toggle,
                           input int inj_idx, input bit pc_walk);
        int got = 0;
        for (int c = 0; c < max_cyc && got < want; c++) begin
            start1 = 1'b0;
            out_ready = toggle ? (c % 2 == 0) : 1'b1;
            if (pc_walk)
                pc = pc + 32'd4;
            if (inj_idx >= 0 && m_valid && int'(m_idx) == inj_idx) begin
                start1 = 1'b1;
                pc     = 32'hDEAD0000;
            end
            if (m_valid && out_ready) begin
                q_idx.push_back(int'(m_idx));
                q_rs.push_back(m_rs);
                q_rt.push_back(m_rt);
                q_pc.push_back(m_pc);
                q_last.push_back(m_last);
                got++;
            end else if (m_valid) begin
                chk({t, "_hold_idx"}, {28'd0, m_idx}, q_idx.size());
                chk({t, "_hold_rs"}, m_rs, 32'h1000 + 2 * q_idx.size());
            end
            tick();
        end
        start1 = 1'b0;
        out_ready = 1'b1;
        if (got < want)
            chk({t, "_timeout"}, got, want);
    endtask

    task automatic vfy(input string t, input logic [31:0] exp_pc);
        chk({t, "_count"}, q_idx.size(), 16);
        for (int k = 0; k < q_idx.size() && k < 16; k++) begin
            chk({t, "_idx"}, q_idx[k], k);
            chk({t, "_rs"}, q_rs[k], 32'h1000 + 2 * k);
            chk({t, "_rt"}, q_rt[k], 32'h1001 + 2 * k);
            chk({t, "_pc"}, q_pc[k], exp_pc);
            chk({t, "_last"}, {31'd0, q_last[k]}, (k == 15) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; start1 = 1'b0; start0 = 1'b0; out_ready = 1'b1; pc = 32'd0; sel = 1'b1;
        tick(); tick();
        chk("rst_rs", {27'd0, rs1}, 0);
        chk("rst_rt", {27'd0, rt1}, 0);
        chk("rst_busy", {31'd0, busy1}, 0);
        chk("rst_drop", {31'd0, drop1}, 0);
        chk("rst_valid", {31'd0, valid1}, 0);
        chk("rst_pc", opc1, 0);
        chk("rst_idx", {28'd0, idx1}, 0);
        chk("rst_rsd", ors1, 0);
        chk("rst_rtd", ort1, 0);
        chk("rst_last", {31'd0, last1}, 0);
        rst = 1'b0;
        tick();

        // 1: basic snapshot, latency RD_LAT+2 = 3
        q_clear();
        pc = 32'h00400020; start1 = 1'b1; tick(); start1 = 1'b0;
        chk("t1_busy", {31'd0, busy1}, 1);
        chk("t1_lat1", {31'd0, valid1}, 0);
        tick();
        chk("t1_lat2", {31'd0, valid1}, 0);
        tick();
        chk("t1_lat3", {31'd0, valid1}, 1);
        collect("t1", 16, 200, 1'b0, -1, 1'b0);
        vfy("t1", 32'h00400020);
        chk("t1_busy_end", {31'd0, busy1}, 0);
        chk("t1_valid_end", {31'd0, valid1}, 0);

        // 2: consumer stalled, credit limits to 8 entries
        q_clear();
        pc = 32'h00400100; start1 = 1'b1; tick(); start1 = 1'b0;
        out_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (rt1 != 5'd0) n++;
            tick();
        end
        chk("t2_issued", n, 8);
        chk("t2_rs_held", {27'd0, rs1}, 0);
        chk("t2_rt_held", {27'd0, rt1}, 0);
        chk("t2_valid", {31'd0, valid1}, 1);
        chk("t2_head_idx", {28'd0, idx1}, 0);
        collect("t2", 16, 200, 1'b0, -1, 1'b0);
        vfy("t2", 32'h00400100);

        // 3: start while busy is dropped
        q_clear();
        chk("t3_drop_pre", {31'd0, drop1}, 0);
        pc = 32'h00400200; start1 = 1'b1; tick(); start1 = 1'b0;
        collect("t3", 16, 200, 1'b0, 5, 1'b0);
        vfy("t3", 32'h00400200);
        chk("t3_drop", {31'd0, drop1}, 1);
        for (int c = 0; c < 6; c++) tick();
        chk("t3_no_extra", {31'd0, valid1}, 0);
        chk("t3_idle", {31'd0, busy1}, 0);
        chk("t3_drop_sticky", {31'd0, drop1}, 1);

        // 4: reset mid-snapshot
        q_clear();
        pc = 32'h00400300; start1 = 1'b1; tick(); start1 = 1'b0;
        collect("t4a", 5, 50, 1'b0, -1, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t4_valid", {31'd0, valid1}, 0);
        chk("t4_busy", {31'd0, busy1}, 0);
        chk("t4_rs", {27'd0, rs1}, 0);
        chk("t4_rt", {27'd0, rt1}, 0);
        chk("t4_drop", {31'd0, drop1}, 0);
        tick();
        q_clear();
        pc = 32'h00400400; start1 = 1'b1; tick(); start1 = 1'b0;
        collect("t4", 16, 200, 1'b0, -1, 1'b0);
        vfy("t4", 32'h00400400);

        // 5: ready toggling
        q_clear();
        pc = 32'h00400500; start1 = 1'b1; tick(); start1 = 1'b0;
        collect("t5", 16, 300, 1'b1, -1, 1'b0);
        vfy("t5", 32'h00400500);

        // 6: zero read latency, pc moving every cycle
        sel = 1'b0;
        q_clear();
        pc = 32'h00400600; start0 = 1'b1; tick(); start0 = 1'b0;
        chk("t6_lat1", {31'd0, valid0}, 0);
        pc = pc + 32'd4;
        tick();
        chk("t6_lat2", {31'd0, valid0}, 1);
        collect("t6", 16, 200, 1'b0, -1, 1'b1);
        vfy("t6", 32'h00400600);
        chk("t6_busy_end", {31'd0, busy0}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
